// File: rtl/dl_pkg.sv
// rtl/dl_pkg.sv - shared state, width helper and report record type for the deadlock report arbiter
package dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    CLEAR,
    DETECT,
    HALT
  } dl_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_N_PROC = 4;
  localparam int DEF_TS_W   = 32;
  localparam int DEF_IDX_W  = idx_w(DEF_N_PROC);

  typedef struct packed {
    logic [DEF_IDX_W-1:0]  origin_idx;
    logic [DEF_N_PROC-1:0] snapshot;
    logic [DEF_TS_W-1:0]   timestamp;
  } dl_rpt_t;

endpackage

// File: rtl/dl_origin_picker.sv
// rtl/dl_origin_picker.sv - combinational origin election: first set request at or after the start pointer
module dl_origin_picker
  import dl_pkg::*;
#(
  parameter int N_PROC = 4,
  parameter int IDX_W  = idx_w(N_PROC)
) (
  input  logic [N_PROC-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [N_PROC-1:0] onehot_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] sel;

  // Scan N_PROC positions starting at ptr_i, wrapping; the first set request wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    sel      = '0;
    for (int k = 0; k < N_PROC; k++) begin
      sel = IDX_W'((int'(ptr_i) + k) % N_PROC);
      if (!valid_o && req_i[sel]) begin
        valid_o       = 1'b1;
        onehot_o[sel] = 1'b1;
        idx_o         = sel;
      end
    end
  end

endmodule

// File: rtl/dl_report_arbiter.sv
// rtl/dl_report_arbiter.sv - deadlock ring arbiter: elect origin, confirm stall, clear tokens, emit one report
// Optional DL_ROTATE_PRIORITY_EN: round-robin origin election instead of fixed lowest-index priority.
module dl_report_arbiter
  import dl_pkg::*;
#(
  parameter int N_PROC         = 4,
  parameter int CONFIRM_CYCLES = 16,
  parameter int TS_W           = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_PROC-1:0]         dl_in_vec,
  output logic [N_PROC-1:0]         origin,
  output logic                      token_clear,
  output logic                      dl_detect_out,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [$clog2(N_PROC)-1:0] rpt_origin_idx,
  output logic [N_PROC-1:0]         rpt_snapshot,
  output logic [TS_W-1:0]           rpt_timestamp
);

  localparam int IDX_W = idx_w(N_PROC);
  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);

  dl_state_e         state_q, state_d;
  logic [N_PROC-1:0] origin_q, origin_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TS_W-1:0]   ts_q;
  logic [IDX_W-1:0]  rpt_idx_q, rpt_idx_d;
  logic [N_PROC-1:0] rpt_snap_q, rpt_snap_d;
  logic [TS_W-1:0]   rpt_ts_q, rpt_ts_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [N_PROC-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              flag;

  assign flag = dl_in_vec[idx_q];

  dl_origin_picker #(
    .N_PROC (N_PROC),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i    (dl_in_vec),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

`ifdef DL_ROTATE_PRIORITY_EN
  // Start the next search just past the unit whose probe was just abandoned.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (state_q == PROBE && !flag) begin
      ptr_q <= (idx_q == IDX_W'(N_PROC - 1)) ? '0 : idx_q + 1'b1;
    end
  end
`else
  assign ptr_q = '0;
`endif

  always_comb begin
    state_d    = state_q;
    origin_d   = origin_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rpt_idx_d  = rpt_idx_q;
    rpt_snap_d = rpt_snap_q;
    rpt_ts_d   = rpt_ts_q;
    case (state_q)
      IDLE: begin
        origin_d = '0;
        if (pick_valid) begin
          origin_d = pick_onehot;
          idx_d    = pick_idx;
          cnt_d    = CNT_W'(1);
          state_d  = PROBE;
        end
      end
      PROBE: begin
        if (!flag) begin
          origin_d = '0;
          cnt_d    = '0;
          state_d  = CLEAR;
        end else if (cnt_q == CNT_W'(CONFIRM_CYCLES)) begin
          rpt_idx_d  = idx_q;
          rpt_snap_d = dl_in_vec;
          rpt_ts_d   = ts_q;
          state_d    = DETECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR:   state_d = IDLE;
      DETECT:  if (rpt_ready) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      origin_q   <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ts_q       <= '0;
      rpt_idx_q  <= '0;
      rpt_snap_q <= '0;
      rpt_ts_q   <= '0;
    end else begin
      state_q    <= state_d;
      origin_q   <= origin_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ts_q       <= ts_q + 1'b1;
      rpt_idx_q  <= rpt_idx_d;
      rpt_snap_q <= rpt_snap_d;
      rpt_ts_q   <= rpt_ts_d;
    end
  end

  assign origin         = origin_q;
  assign token_clear    = (state_q == CLEAR);
  assign dl_detect_out  = (state_q == DETECT) || (state_q == HALT);
  assign rpt_valid      = (state_q == DETECT);
  assign rpt_origin_idx = rpt_idx_q;
  assign rpt_snapshot   = rpt_snap_q;
  assign rpt_timestamp  = rpt_ts_q;

endmodule

// File: tb/tb_dl_report_arbiter.sv
// tb/tb_dl_report_arbiter.sv - directed scoreboard bench for dl_report_arbiter (N_PROC=4, CONFIRM_CYCLES=16)
module tb_dl_report_arbiter;
  import dl_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  dl_in_vec;
  logic [3:0]  origin;
  logic        token_clear;
  logic        dl_detect_out;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [1:0]  rpt_origin_idx;
  logic [3:0]  rpt_snapshot;
  logic [31:0] rpt_timestamp;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc;
  dl_rpt_t     exp_q[$];

  dl_report_arbiter #(
    .N_PROC         (4),
    .CONFIRM_CYCLES (16),
    .TS_W           (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dl_in_vec      (dl_in_vec),
    .origin         (origin),
    .token_clear    (token_clear),
    .dl_detect_out  (dl_detect_out),
    .rpt_valid      (rpt_valid),
    .rpt_ready      (rpt_ready),
    .rpt_origin_idx (rpt_origin_idx),
    .rpt_snapshot   (rpt_snapshot),
    .rpt_timestamp  (rpt_timestamp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle count since reset release: the timestamp a confirmation edge must report.
  always @(posedge clock) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("no_x", 64'($isunknown({origin, token_clear, dl_detect_out, rpt_valid,
                                  rpt_origin_idx, rpt_snapshot, rpt_timestamp})), 64'd0);
      if (rpt_valid && rpt_ready) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          dl_rpt_t e;
          e = exp_q.pop_front();
          chk("sb_idx", 64'(rpt_origin_idx), 64'(e.origin_idx));
          chk("sb_snap", 64'(rpt_snapshot), 64'(e.snapshot));
          chk("sb_ts", 64'(rpt_timestamp), 64'(e.timestamp));
        end
      end
    end
  end

  initial begin
    int          bad;
    logic [31:0] ts0;
    logic [3:0]  exp_o;
    dl_rpt_t     e;

    reset     = 1'b1;
    dl_in_vec = '0;
    rpt_ready = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", 64'({origin, token_clear, dl_detect_out, rpt_valid}), 64'd0);
    chk("rst_record", 64'({rpt_origin_idx, rpt_snapshot, rpt_timestamp}), 64'd0);

    // Quiet idle
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (origin !== 4'b0 || token_clear !== 1'b0 || dl_detect_out !== 1'b0 || rpt_valid !== 1'b0) bad++;
    end
    chk("idle_quiet", 64'(bad), 64'd0);

    // Probe abandoned after 5 flagged cycles
    dl_in_vec = 4'b0010;
    tick();
    chk("probe_origin", 64'(origin), 64'h2);
    bad = 0;
    repeat (4) begin
      tick();
      if (origin !== 4'b0010 || token_clear !== 1'b0) bad++;
    end
    chk("probe_hold", 64'(bad), 64'd0);
    dl_in_vec = 4'b0000;
    tick();
    chk("clear_pulse", 64'(token_clear), 64'd1);
    chk("clear_origin", 64'(origin), 64'd0);
    tick();
    chk("clear_one_cycle", 64'(token_clear), 64'd0);
    chk("abort_no_detect", 64'({dl_detect_out, rpt_valid}), 64'd0);

    // Confirmed deadlock with back-pressured report
    rpt_ready = 1'b0;
    dl_in_vec = 4'b0110;
    ts0 = cyc;
    e.origin_idx = 2'd1;
    e.snapshot   = 4'b0110;
    e.timestamp  = ts0 + 32'd16;
    exp_q.push_back(e);
    tick();
    chk("det_origin", 64'(origin), 64'h2);
    bad = 0;
    repeat (15) begin
      tick();
      if (dl_detect_out !== 1'b0 || rpt_valid !== 1'b0 || origin !== 4'b0010) bad++;
    end
    chk("confirm_wait", 64'(bad), 64'd0);
    tick();
    chk("det_out", 64'(dl_detect_out), 64'd1);
    chk("det_valid", 64'(rpt_valid), 64'd1);
    chk("det_idx", 64'(rpt_origin_idx), 64'(e.origin_idx));
    chk("det_snap", 64'(rpt_snapshot), 64'(e.snapshot));
    chk("det_ts", 64'(rpt_timestamp), 64'(e.timestamp));

    dl_in_vec = 4'b1001;
    bad = 0;
    repeat (10) begin
      tick();
      if (rpt_valid !== 1'b1 || rpt_origin_idx !== e.origin_idx || rpt_snapshot !== e.snapshot ||
          rpt_timestamp !== e.timestamp || origin !== 4'b0010) bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    rpt_ready = 1'b1;
    tick();
    chk("valid_drop", 64'(rpt_valid), 64'd0);
    chk("halt_detect", 64'(dl_detect_out), 64'd1);
    bad = 0;
    repeat (30) begin
      dl_in_vec = 4'($urandom_range(0, 15));
      tick();
      if (rpt_valid !== 1'b0 || dl_detect_out !== 1'b1 || token_clear !== 1'b0 || origin !== 4'b0010) bad++;
    end
    chk("halt_quiet", 64'(bad), 64'd0);
    chk("sb_drained_1", 64'(exp_q.size()), 64'd0);

    // Reset in HALT, then a fresh probe with ready tied high
    reset = 1'b1;
    tick();
    chk("halt_reset", 64'({origin, token_clear, dl_detect_out, rpt_valid,
                           rpt_origin_idx, rpt_snapshot, rpt_timestamp}), 64'd0);
    reset = 1'b0;
    dl_in_vec = 4'b1000;
    ts0 = cyc;
    e.origin_idx = 2'd3;
    e.snapshot   = 4'b1000;
    e.timestamp  = ts0 + 32'd16;
    exp_q.push_back(e);
    tick();
    chk("reprobe_origin", 64'(origin), 64'h8);
    repeat (15) tick();
    tick();
    chk("reprobe_valid", 64'({dl_detect_out, rpt_valid}), 64'h3);
    tick();
    chk("valid_one_cycle", 64'(rpt_valid), 64'd0);
    chk("sb_drained_2", 64'(exp_q.size()), 64'd0);

    // Reset during PROBE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dl_in_vec = 4'b0100;
    tick();
    chk("probe2_origin", 64'(origin), 64'h4);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("probe_reset", 64'({origin, token_clear, dl_detect_out, rpt_valid,
                            rpt_origin_idx, rpt_snapshot, rpt_timestamp}), 64'd0);
    reset = 1'b0;
    dl_in_vec = 4'b0000;
    tick();

    // Election order under contention
    for (int p = 0; p < 5; p++) begin
      dl_in_vec = 4'b1111;
      tick();
`ifdef DL_ROTATE_PRIORITY_EN
      exp_o = 4'b0001 << (p % 4);
`else
      exp_o = 4'b0001;
`endif
      chk("rr_origin", 64'(origin), 64'(exp_o));
      repeat (2) tick();
      dl_in_vec = 4'b1111 & ~exp_o;
      tick();
      chk("rr_clear", 64'(token_clear), 64'd1);
      dl_in_vec = 4'b1111;
      tick();
      chk("rr_gap", 64'({origin, token_clear}), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
